// File: rtl/dcache_wb_assoc.sv
// Write-back, write-allocate data cache (1 or 2 ways, LRU) with a beat-serial memory port.
// Misses write back a dirty victim before the fill; supports a clean-flush walk and invalidate-all.
module dcache_wb_assoc #(
  parameter int RV          = 16,
  parameter int PA          = 22,
  parameter int LINE_LENGTH = 4,
  parameter int NLINES      = 4,
  parameter int WAYS        = 2,
  parameter int BUS         = 4
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              req,
  input  logic                              write,
  input  logic                              is_byte,
  input  logic                              fault,
  input  logic [PA-1:0]                     paddr,
  input  logic [RV-1:0]                     wdata,
  output logic [RV-1:0]                     rdata,
  output logic                              ready,
  input  logic                              flush_clean,
  input  logic                              flush_inv,
  output logic                              busy,
  output logic                              mem_req,
  output logic                              mem_we,
  output logic [PA-$clog2(LINE_LENGTH)-1:0] mem_addr,
  output logic [BUS-1:0]                    mem_wdata,
  input  logic [BUS-1:0]                    mem_rdata,
  input  logic                              mem_ack
);
  localparam int LB     = LINE_LENGTH * 8;
  localparam int NBEATS = LB / BUS;
  localparam int OFFW   = $clog2(LINE_LENGTH);
  localparam int IDXW   = $clog2(NLINES);
  localparam int TAGW   = PA - OFFW - IDXW;
  localparam int BW     = (NBEATS > 1) ? $clog2(NBEATS) : 1;
  localparam int NENT   = NLINES * WAYS;
  localparam int EW     = (NENT > 1) ? $clog2(NENT) : 1;
  localparam logic [OFFW-1:0] WMASK = ~OFFW'(RV/8 - 1);

  typedef enum logic [1:0] {IDLE, WB, FILL, FLUSH} state_t;
  state_t state, nstate;

  logic [LB-1:0]               data_arr [WAYS][NLINES];
  logic [TAGW-1:0]             tag_arr  [WAYS][NLINES];
  logic [NLINES-1:0][WAYS-1:0] valid, dirty;
  logic [NLINES-1:0]           lru;   // per set: which way is least recently used

  logic [BW-1:0]   beat;
  logic            vway;
  logic [IDXW-1:0] vidx;
  logic [TAGW-1:0] ftag;
  logic [EW-1:0]   fcnt;
  logic            from_flush, inv_pend;

  logic [IDXW-1:0] idx;
  logic [TAGW-1:0] ptag;
  logic [OFFW-1:0] boff, woff;
  logic [WAYS-1:0] hit_way;
  logic            hway, vsel, hit_any, acc, hit, miss, last_beat, beat_done;
  logic [IDXW-1:0] f_set;
  logic            f_way, f_dirty, f_last;
  logic [LB-1:0]   rd_line, wb_line;

  assign idx  = paddr[OFFW +: IDXW];
  assign ptag = paddr[PA-1 -: TAGW];
  assign boff = paddr[OFFW-1:0];
  assign woff = boff & WMASK;

  always_comb begin
    hit_way = '0;
    hway    = 1'b0;
    for (int w = 0; w < WAYS; w++) begin
      hit_way[w] = valid[idx][w] && (tag_arr[w][idx] == ptag);
      if (hit_way[w]) hway = 1'(w);
    end
  end

  // Lowest-numbered invalid way wins over the LRU way.
  always_comb begin
    vsel = (WAYS > 1) ? lru[idx] : 1'b0;
    for (int w = WAYS - 1; w >= 0; w--)
      if (!valid[idx][w]) vsel = 1'(w);
  end

  // Flush inputs take precedence over a request in the same cycle.
  assign hit_any   = |hit_way;
  assign acc       = (state == IDLE) && req && !fault && !flush_clean && !flush_inv;
  assign hit       = acc && hit_any;
  assign miss      = acc && !hit_any;
  assign last_beat = (beat == BW'(NBEATS - 1));
  assign beat_done = mem_ack && last_beat;

  assign f_set   = IDXW'(fcnt >> (WAYS - 1));
  assign f_way   = (WAYS > 1) ? fcnt[0] : 1'b0;
  assign f_dirty = valid[f_set][f_way] && dirty[f_set][f_way];
  assign f_last  = (fcnt == EW'(NENT - 1));

  assign rd_line = data_arr[hway][idx];
  assign wb_line = data_arr[vway][vidx];

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= nstate;
  end

  always_comb begin
    nstate = state;
    case (state)
      IDLE:    if (flush_clean) nstate = FLUSH;
               else if (miss) nstate = (valid[idx][vsel] && dirty[idx][vsel]) ? WB : FILL;
      WB:      if (beat_done) nstate = from_flush ? FLUSH : FILL;
      FILL:    if (beat_done) nstate = IDLE;
      FLUSH:   if (f_dirty) nstate = WB;
               else if (f_last) nstate = IDLE;
      default: nstate = IDLE;
    endcase
  end

  always_comb begin
    busy      = (state != IDLE);
    ready     = hit;
    mem_req   = (state == WB) || (state == FILL);
    mem_we    = (state == WB);
    mem_addr  = '0;
    mem_wdata = '0;
    rdata     = '0;
    if (hit && !write)
      rdata = is_byte ? RV'(rd_line[boff*8 +: 8]) : rd_line[woff*8 +: RV];
    if (state == WB) begin
      mem_addr  = {tag_arr[vway][vidx], vidx};
      mem_wdata = wb_line[beat*BUS +: BUS];
    end else if (state == FILL) begin
      mem_addr  = {ftag, vidx};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      valid      <= '0;
      dirty      <= '0;
      lru        <= '0;
      beat       <= '0;
      vway       <= 1'b0;
      vidx       <= '0;
      ftag       <= '0;
      fcnt       <= '0;
      from_flush <= 1'b0;
      inv_pend   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (flush_clean) begin
            fcnt       <= '0;
            from_flush <= 1'b1;
            inv_pend   <= flush_inv;
          end else if (flush_inv) begin
            valid <= '0;
            dirty <= '0;
          end else if (hit) begin
            lru[idx] <= ~hway;
            if (write) dirty[idx][hway] <= 1'b1;
          end else if (miss) begin
            vway       <= vsel;
            vidx       <= idx;
            ftag       <= ptag;
            from_flush <= 1'b0;
            beat       <= '0;
          end
        end
        WB, FILL: if (mem_ack) begin
          beat <= last_beat ? '0 : beat + 1'b1;
          if (last_beat) begin
            dirty[vidx][vway] <= 1'b0;
            if (state == FILL) begin
              valid[vidx][vway] <= 1'b1;
              lru[vidx]         <= ~vway;
            end
          end
        end
        // A written-back entry is revisited once; it is then clean and the walk moves on.
        FLUSH: begin
          if (f_dirty) begin
            vway <= f_way;
            vidx <= f_set;
            beat <= '0;
          end else if (f_last) begin
            if (inv_pend) begin
              valid <= '0;
              dirty <= '0;
            end
            inv_pend <= 1'b0;
          end else begin
            fcnt <= fcnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Line storage carries no reset; valid bits alone decide what is live.
  always_ff @(posedge clk) begin
    if (!reset) begin
      if (hit && write) begin
        if (is_byte) data_arr[hway][idx][boff*8 +: 8]  <= wdata[7:0];
        else         data_arr[hway][idx][woff*8 +: RV] <= wdata;
      end
      if (state == FILL && mem_ack) begin
        data_arr[vway][vidx][beat*BUS +: BUS] <= mem_rdata;
        if (last_beat) tag_arr[vway][vidx] <= ftag;
      end
    end
  end
endmodule

// File: tb/tb_dcache_wb_assoc.sv
// Bench for dcache_wb_assoc: memory responder plus a flat-memory / recency-list reference model.
module tb_dcache_wb_assoc;
  localparam int RV = 16, PA = 22, LINE_LENGTH = 4, NLINES = 4, WAYS = 2, BUS = 4;
  localparam int LB = LINE_LENGTH * 8, NB = LB / BUS, OFFW = $clog2(LINE_LENGTH);
  localparam int IDXW = $clog2(NLINES), LAW = PA - OFFW;

  logic clk = 1'b0;
  logic reset = 1'b1, req = 1'b0, write = 1'b0, is_byte = 1'b0, fault = 1'b0;
  logic flush_clean = 1'b0, flush_inv = 1'b0, mem_ack = 1'b0;
  logic [PA-1:0]  paddr = '0;
  logic [RV-1:0]  wdata = '0, rdata;
  logic           ready, busy, mem_req, mem_we;
  logic [LAW-1:0] mem_addr;
  logic [BUS-1:0] mem_wdata, mem_rdata = '0;
  int checks = 0, errors = 0;

  always #5 clk = ~clk;

  dcache_wb_assoc #(.RV(RV), .PA(PA), .LINE_LENGTH(LINE_LENGTH), .NLINES(NLINES),
                    .WAYS(WAYS), .BUS(BUS)) dut (
    .clk(clk), .reset(reset), .req(req), .write(write), .is_byte(is_byte), .fault(fault),
    .paddr(paddr), .wdata(wdata), .rdata(rdata), .ready(ready),
    .flush_clean(flush_clean), .flush_inv(flush_inv), .busy(busy),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack));

  // backing memory and the architecturally visible memory contents
  logic [LB-1:0] bmem  [int];
  logic [LB-1:0] truth [int];

  function automatic logic [LB-1:0] bget(int la);
    if (!bmem.exists(la)) bmem[la] = LB'(la * 32'h9E3779B1 ^ 32'h5A5A1234);
    return bmem[la];
  endfunction

  function automatic logic [LB-1:0] tget(int la);
    if (!truth.exists(la)) truth[la] = bget(la);
    return truth[la];
  endfunction

  typedef struct {bit we; int addr; logic [LB-1:0] data;} burst_t;
  burst_t blog[$];
  int rk = 0, wb_beats = 0, memreq_cycles = 0;
  bit stall_en = 0;
  logic [LB-1:0] wbuf = '0, fbuf = '0;

  always @(negedge clk) begin
    logic [LB-1:0] ln;
    mem_ack = 1'b0;
    if (reset) rk = 0;
    else if (mem_req) begin
      memreq_cycles++;
      if (!stall_en || $urandom_range(0, 2) != 0) begin
        mem_ack = 1'b1;
        if (mem_we) begin
          wbuf[rk*BUS +: BUS] = mem_wdata;
          wb_beats++;
        end else begin
          ln = bget(int'(mem_addr));
          mem_rdata = ln[rk*BUS +: BUS];
          fbuf[rk*BUS +: BUS] = mem_rdata;
        end
        if (rk == NB - 1) begin
          if (mem_we) bmem[int'(mem_addr)] = wbuf;
          blog.push_back('{mem_we, int'(mem_addr), mem_we ? wbuf : fbuf});
          rk = 0;
        end else rk++;
      end
    end
  end

  // per set: resident lines ordered most- to least-recently used
  typedef struct {int tag; bit dirty;} ent_t;
  ent_t ms [NLINES][WAYS];
  int   mcnt [NLINES];

  function automatic void m_lose_all();
    for (int s = 0; s < NLINES; s++) begin
      for (int i = 0; i < mcnt[s]; i++)
        if (ms[s][i].dirty) truth[ms[s][i].tag*NLINES + s] = bget(ms[s][i].tag*NLINES + s);
      mcnt[s] = 0;
    end
  endfunction

  function automatic int m_ndirty();
    int n = 0;
    for (int s = 0; s < NLINES; s++)
      for (int i = 0; i < mcnt[s]; i++) if (ms[s][i].dirty) n++;
    return n;
  endfunction

  function automatic void m_clean();
    for (int s = 0; s < NLINES; s++)
      for (int i = 0; i < WAYS; i++) ms[s][i].dirty = 0;
  endfunction

  task automatic do_access(input bit wr, input bit byt, input int addr,
                           input logic [RV-1:0] wd, output logic [RV-1:0] rd, output int cyc);
    int set, tag, la, pos, wb0, bo, wo;
    bit vdirty;
    logic [LB-1:0] ln;
    logic [RV-1:0] exp;
    ent_t e;
    set = (addr >> OFFW) % NLINES;
    tag = addr >> (OFFW + IDXW);
    la  = addr >> OFFW;
    bo  = addr % LINE_LENGTH;
    wo  = bo & ~(RV/8 - 1);
    pos = -1;
    for (int i = 0; i < mcnt[set]; i++) if (ms[set][i].tag == tag) pos = i;
    vdirty = (pos < 0 && mcnt[set] == WAYS) ? ms[set][WAYS-1].dirty : 1'b0;
    wb0 = wb_beats;
    @(posedge clk); #1;
    req = 1'b1; write = wr; is_byte = byt; paddr = PA'(addr); wdata = wd; fault = 1'b0;
    cyc = 0;
    @(negedge clk);
    while (!ready && cyc < 300) begin @(negedge clk); cyc++; end
    rd = rdata;
    ln = tget(la);
    exp = byt ? RV'(ln[bo*8 +: 8]) : ln[wo*8 +: RV];
    checks++;
    if (!ready) begin
      errors++; $display("FAIL access_ready addr=%h got 0 want 1", addr);
    end else begin
      checks++;
      if ((cyc == 0) !== (pos >= 0)) begin
        errors++; $display("FAIL hit_latency addr=%h got %0d cycles want hit=%0d", addr, cyc, pos >= 0);
      end
      checks++;
      if (wb_beats - wb0 !== (vdirty ? NB : 0)) begin
        errors++; $display("FAIL victim_wb_beats addr=%h got %0d want %0d", addr, wb_beats - wb0, vdirty ? NB : 0);
      end
      if (!wr) begin
        checks++;
        if (rd !== exp) begin
          errors++; $display("FAIL load_data addr=%h byte=%0d got %h want %h", addr, byt, rd, exp);
        end
      end
    end
    @(posedge clk); #1;
    req = 1'b0; write = 1'b0;
    if (wr) begin
      if (byt) ln[bo*8 +: 8] = wd[7:0];
      else     ln[wo*8 +: RV] = wd;
      truth[la] = ln;
    end
    if (pos >= 0) begin
      e = ms[set][pos];
      for (int i = pos; i > 0; i--) ms[set][i] = ms[set][i-1];
    end else begin
      e.tag = tag; e.dirty = 1'b0;
      if (mcnt[set] < WAYS) mcnt[set]++;
      for (int i = mcnt[set] - 1; i > 0; i--) ms[set][i] = ms[set][i-1];
    end
    e.dirty = e.dirty | wr;
    ms[set][0] = e;
  endtask

  task automatic do_flush(input bit cl, input bit inv, output int bcyc, output int beats);
    int b0, nd;
    b0 = wb_beats;
    nd = m_ndirty();
    @(posedge clk); #1; flush_clean = cl; flush_inv = inv;
    @(posedge clk); #1; flush_clean = 1'b0; flush_inv = 1'b0;
    bcyc = 0;
    @(negedge clk);
    while (busy && bcyc < 2000) begin bcyc++; @(negedge clk); end
    beats = wb_beats - b0;
    checks++;
    if (busy) begin errors++; $display("FAIL flush_timeout got busy=1 want 0"); end
    checks++;
    if (beats !== (cl ? nd * NB : 0)) begin
      errors++; $display("FAIL flush_beats got %0d want %0d", beats, cl ? nd * NB : 0);
    end
    if (cl) begin
      checks++;
      if ((nd == 0 && bcyc !== NLINES*WAYS) || bcyc < NLINES*WAYS) begin
        errors++; $display("FAIL flush_busy_cycles got %0d want %0d (dirty=%0d)", bcyc, NLINES*WAYS, nd);
      end
      m_clean();
    end else begin
      checks++;
      if (bcyc !== 0) begin errors++; $display("FAIL inv_busy got %0d want 0", bcyc); end
    end
    if (inv) m_lose_all();
  endtask

  task automatic apply_reset();
    @(posedge clk); #1; reset = 1'b1; req = 1'b0;
    repeat (2) @(posedge clk);
    #1; reset = 1'b0;
    m_lose_all();
  endtask

  task automatic test_reset();
    apply_reset();
    @(negedge clk);
    checks += 5;
    if (ready !== 1'b0)   begin errors++; $display("FAIL reset_ready got %b want 0", ready); end
    if (busy !== 1'b0)    begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
    if (mem_req !== 1'b0) begin errors++; $display("FAIL reset_mem_req got %b want 0", mem_req); end
    if (mem_we !== 1'b0)  begin errors++; $display("FAIL reset_mem_we got %b want 0", mem_we); end
    if (rdata !== '0)     begin errors++; $display("FAIL reset_rdata got %h want 0", rdata); end
  endtask

  task automatic test_cold_fill();
    logic [RV-1:0] rd; int cyc, m0;
    bmem[4] = 32'h87654321;
    blog.delete();
    do_access(0, 0, 'h10, '0, rd, cyc);
    checks += 2;
    if (rd !== 16'h4321) begin errors++; $display("FAIL cold_fill_rdata got %h want 4321", rd); end
    if (blog.size() != 1 || blog[0].we || blog[0].addr != 4) begin
      errors++; $display("FAIL cold_fill_burst got n=%0d we=%0d addr=%h want 1 fill at 4",
                         blog.size(), blog.size() ? blog[0].we : 1'b0, blog.size() ? blog[0].addr : 0);
    end
    m0 = memreq_cycles;
    do_access(0, 0, 'h12, '0, rd, cyc);
    checks += 2;
    if (rd !== 16'h8765) begin errors++; $display("FAIL hit_rdata got %h want 8765", rd); end
    if (memreq_cycles != m0) begin errors++; $display("FAIL hit_mem_req got %0d want 0", memreq_cycles - m0); end
  endtask

  task automatic test_store_hit();
    logic [RV-1:0] rd; int cyc;
    do_access(1, 0, 'h10, 16'hBEEF, rd, cyc);
    checks++;
    if (cyc != 0) begin errors++; $display("FAIL store_hit_latency got %0d want 0", cyc); end
    do_access(0, 0, 'h10, '0, rd, cyc);
    checks++;
    if (rd !== 16'hBEEF) begin errors++; $display("FAIL store_reload got %h want beef", rd); end
  endtask

  task automatic test_lru_wb();
    logic [RV-1:0] rd; int cyc;
    blog.delete();
    do_access(0, 0, 'h20, '0, rd, cyc);
    do_access(0, 0, 'h30, '0, rd, cyc);
    checks += 2;
    if (blog.size() != 3 || !blog[1].we || blog[1].addr != 4 || blog[1].data !== 32'h8765BEEF) begin
      errors++; $display("FAIL lru_wb_burst got n=%0d we=%0d addr=%h data=%h want wb at 4 data 8765beef",
                         blog.size(), blog.size() > 1 ? blog[1].we : 1'b0,
                         blog.size() > 1 ? blog[1].addr : 0, blog.size() > 1 ? blog[1].data : '0);
    end
    if (blog.size() != 3 || blog[2].we || blog[2].addr != 'hC) begin
      errors++; $display("FAIL lru_fill_burst got n=%0d addr=%h want fill at c",
                         blog.size(), blog.size() > 2 ? blog[2].addr : 0);
    end
  endtask

  task automatic test_byte();
    logic [RV-1:0] rd; int cyc;
    do_access(1, 1, 'h21, 16'h33A5, rd, cyc);
    do_access(0, 1, 'h21, '0, rd, cyc);
    checks++;
    if (rd !== 16'h00A5) begin errors++; $display("FAIL byte_load got %h want 00a5", rd); end
    do_access(0, 0, 'h20, '0, rd, cyc);
    checks++;
    if (rd[15:8] !== 8'hA5) begin errors++; $display("FAIL byte_in_word got %h want a5", rd[15:8]); end
  endtask

  task automatic test_flush_clean();
    logic [RV-1:0] rd; int cyc, bc, bt;
    do_access(1, 0, 'h14, 16'h1234, rd, cyc);
    checks++;
    if (m_ndirty() != 2) begin errors++; $display("FAIL flush_setup got %0d dirty want 2", m_ndirty()); end
    do_flush(1, 0, bc, bt);
    checks++;
    if (bt != 16) begin errors++; $display("FAIL flush_clean_beats got %0d want 16", bt); end
    do_flush(1, 0, bc, bt);
    checks += 2;
    if (bt != 0) begin errors++; $display("FAIL reflush_beats got %0d want 0", bt); end
    if (bc != NLINES*WAYS) begin errors++; $display("FAIL reflush_busy got %0d want %0d", bc, NLINES*WAYS); end
  endtask

  task automatic test_fault_reset();
    logic [RV-1:0] rd; int cyc, m0, n;
    m0 = memreq_cycles;
    @(posedge clk); #1;
    req = 1'b1; write = 1'b1; fault = 1'b1; paddr = PA'('h100); wdata = 16'hDEAD;
    repeat (3) begin
      @(negedge clk);
      checks++;
      if (ready !== 1'b0) begin errors++; $display("FAIL fault_ready got %b want 0", ready); end
    end
    @(posedge clk); #1; req = 1'b0; write = 1'b0; fault = 1'b0;
    checks++;
    if (memreq_cycles != m0 || busy !== 1'b0) begin
      errors++; $display("FAIL fault_mem_req got %0d cycles busy=%b want 0 0", memreq_cycles - m0, busy);
    end
    req = 1'b1; paddr = PA'('h200); is_byte = 1'b0;
    n = 0;
    while (!(mem_req && !mem_we && rk == 3) && n < 100) begin @(posedge clk); #1; n++; end
    checks++;
    if (n >= 100) begin errors++; $display("FAIL fill_beat3_timeout got %0d want <100", n); end
    reset = 1'b1; req = 1'b0;
    @(posedge clk); #1; reset = 1'b0;
    m_lose_all();
    @(negedge clk);
    checks++;
    if (mem_req !== 1'b0) begin errors++; $display("FAIL reset_midburst_mem_req got %b want 0", mem_req); end
    do_access(0, 0, 'h200, '0, rd, cyc);
    checks++;
    if (cyc == 0) begin errors++; $display("FAIL after_reset_miss got %0d cycles want >0", cyc); end
  endtask

  task automatic test_random();
    logic [RV-1:0] rd; int cyc, bc, bt, r;
    stall_en = 1;
    for (int i = 0; i < 200; i++) begin
      r = $urandom_range(0, 24);
      if (r == 0)      do_flush(1, 0, bc, bt);
      else if (r == 1) do_flush(0, 1, bc, bt);
      else if (r == 2) do_flush(1, 1, bc, bt);
      else do_access($urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 'hFF),
                     RV'($urandom), rd, cyc);
    end
    do_flush(1, 0, bc, bt);
    foreach (truth[k]) begin
      checks++;
      if (bget(k) !== truth[k]) begin
        errors++; $display("FAIL memory_image line=%h got %h want %h", k, bget(k), truth[k]);
      end
    end
    stall_en = 0;
  endtask

  initial begin
    for (int s = 0; s < NLINES; s++) mcnt[s] = 0;
    test_reset();
    test_cold_fill();
    test_store_hit();
    test_lru_wb();
    test_byte();
    test_flush_clean();
    test_fault_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout got running want finished");
    $fatal(1);
  end
endmodule
